// File: rtl/rr_arbiter_mux2_1_2bit.sv
// Two-channel round-robin arbiter feeding a one-entry registered output
// with valid/ready handshakes and per-channel transfer counters.
module rr_arbiter_mux2_1_2bit #(
    parameter int DATA_WIDTH    = 2,
    parameter int CNT_WIDTH     = 8,
    parameter int PRIORITY_INIT = 0
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  select_out,
    output logic [CNT_WIDTH-1:0]  count0,
    output logic [CNT_WIDTH-1:0]  count1
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic state;
    logic prio;
    logic can_load;
    logic grant_any;
    logic grant;
    logic xfer0;
    logic xfer1;

    assign out_valid = (state == FULL);

    // Readies are held low while reset is asserted so nothing is accepted.
    assign can_load  = reset_L & ((state == EMPTY) | (out_ready & out_valid));
    assign grant_any = in0_valid | in1_valid;
    assign grant     = (in0_valid & in1_valid) ? prio : in1_valid;

    assign in0_ready = can_load & grant_any & ~grant;
    assign in1_ready = can_load & grant_any & grant;

    assign xfer0 = in0_valid & in0_ready;
    assign xfer1 = in1_valid & in1_ready;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= EMPTY;
            out_data   <= '0;
            select_out <= 1'b0;
            count0     <= '0;
            count1     <= '0;
            prio       <= 1'(PRIORITY_INIT);
        end else begin
            unique case (1'b1)
                xfer0: begin
                    state      <= FULL;
                    out_data   <= in0_data;
                    select_out <= 1'b0;
                    count0     <= count0 + CNT_WIDTH'(1);
                    prio       <= 1'b1;
                end
                xfer1: begin
                    state      <= FULL;
                    out_data   <= in1_data;
                    select_out <= 1'b1;
                    count1     <= count1 + CNT_WIDTH'(1);
                    prio       <= 1'b0;
                end
                default: begin
                    if (out_valid && out_ready) begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_mux2_1_2bit.sv
// Directed-vector bench for the round-robin arbiter: table of per-cycle
// stimulus/expectations plus hand sequences for reset and counter wrap.
module tb_rr_arbiter_mux2_1_2bit;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [1:0] in0_data;
    logic       in0_valid;
    logic       in0_ready;
    logic [1:0] in1_data;
    logic       in1_valid;
    logic       in1_ready;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       select_out;
    logic [7:0] count0;
    logic [7:0] count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_mux2_1_2bit #(
        .DATA_WIDTH(2),
        .CNT_WIDTH(8),
        .PRIORITY_INIT(0)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .in0_data(in0_data),
        .in0_valid(in0_valid),
        .in0_ready(in0_ready),
        .in1_data(in1_data),
        .in1_valid(in1_valid),
        .in1_ready(in1_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .select_out(select_out),
        .count0(count0),
        .count1(count1)
    );

    typedef struct {
        logic       v0;
        logic [1:0] d0;
        logic       v1;
        logic [1:0] d1;
        logic       ordy;
        logic       r0;
        logic       r1;
        logic       ov;
        logic [1:0] od;
        logic       sel;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // v0 d0 v1 d1 ordy | r0 r1 ov od sel
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1};
        vecs[2]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[3]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1};
        vecs[4]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1};
        vecs[6]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[9]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[11] = '{1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[12] = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[13] = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1};

        reset_L   = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 2'b01;
        in1_data  = 2'b11;
        out_ready = 1'b1;

        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_count0", 32'(count0), 32'd0);
        check("rst_count1", 32'(count1), 32'd0);
        check("rst_in0_ready", 32'(in0_ready), 32'd0);
        check("rst_in1_ready", 32'(in1_ready), 32'd0);

        reset_L = 1'b1;
        #1;
        check("rel_in0_ready", 32'(in0_ready), 32'd1);
        check("rel_in1_ready", 32'(in1_ready), 32'd0);

        for (int i = 0; i < 15; i++) begin
            in0_valid = vecs[i].v0;
            in0_data  = vecs[i].d0;
            in1_valid = vecs[i].v1;
            in1_data  = vecs[i].d1;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_in0_ready", i), 32'(in0_ready), 32'(vecs[i].r0));
            check($sformatf("v%0d_in1_ready", i), 32'(in1_ready), 32'(vecs[i].r1));
            step();
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
            check($sformatf("v%0d_select_out", i), 32'(select_out), 32'(vecs[i].sel));
        end
        check("tbl_count0", 32'(count0), 32'd4);
        check("tbl_count1", 32'(count1), 32'd5);

        // Fill, then hit reset mid-cycle well before the next edge.
        in0_valid = 1'b1;
        in0_data  = 2'b10;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        step();
        check("pre_arst_out_valid", 32'(out_valid), 32'd1);
        #2;
        reset_L = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_count0", 32'(count0), 32'd0);
        check("arst_count1", 32'(count1), 32'd0);

        @(negedge clk);
        reset_L   = 1'b1;
        out_ready = 1'b1;
        in0_data  = 2'b01;
        step();
        check("recover_out_valid", 32'(out_valid), 32'd1);
        check("recover_select", 32'(select_out), 32'd0);
        check("recover_count0", 32'(count0), 32'd1);

        repeat (254) step();
        check("wrap_count0_ff", 32'(count0), 32'hff);
        step();
        check("wrap_count0_00", 32'(count0), 32'h00);
        check("wrap_count1", 32'(count1), 32'd0);
        check("wrap_out_data", 32'(out_data), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
